// File: rtl/ghr_ckpt_pkg.sv
// Shared definitions for the speculative global history checkpoint block.
package ghr_ckpt_pkg;

  // Default history length and checkpoint ring depth for the branch predictor.
  localparam int GHR_WIDTH_DEF      = 5;
  localparam int GHR_CKPT_DEPTH_DEF = 8;

  // Which update drives the speculative history in a given cycle.
  // Flush outranks recover, and recover outranks a new prediction.
  typedef enum logic [1:0] {
    OP_IDLE    = 2'd0,
    OP_PRED    = 2'd1,
    OP_RECOVER = 2'd2,
    OP_FLUSH   = 2'd3
  } spec_op_e;

endpackage

// File: rtl/ghr_ckpt_ram.sv
// Checkpoint storage: one synchronous write port, one asynchronous read port.
// Contents are not reset; a slot is only read after it has been written.
module ghr_ckpt_ram #(
  parameter int WIDTH    = 5,
  parameter int DEPTH    = 8,
  parameter int ID_WIDTH = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                wr_en,
  input  logic [ID_WIDTH-1:0] wr_addr,
  input  logic [WIDTH-1:0]    wr_data,
  input  logic [ID_WIDTH-1:0] rd_addr,
  output logic [WIDTH-1:0]    rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Capture the pre-shift history of an accepted branch.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Recovery reads the checkpoint in the same cycle the id is presented.
  always_comb begin
    rd_data = mem[rd_addr];
  end

endmodule

// File: rtl/ghr_ckpt.sv
// Speculative GHR with per-branch checkpoints, single-cycle misprediction
// repair, in-order architectural GHR and full-flush restore.
module ghr_ckpt
  import ghr_ckpt_pkg::*;
#(
  parameter int GHR_WIDTH     = GHR_WIDTH_DEF,
  parameter int CKPT_DEPTH    = GHR_CKPT_DEPTH_DEF,
  parameter int CKPT_ID_WIDTH = $clog2(CKPT_DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     pred_valid,
  input  logic                     pred_taken,
  output logic                     pred_ready,
  output logic [CKPT_ID_WIDTH-1:0] pred_id,
  input  logic                     recover_valid,
  input  logic [CKPT_ID_WIDTH-1:0] recover_id,
  input  logic                     recover_taken,
  input  logic                     commit_valid,
  input  logic                     commit_taken,
  input  logic                     flush_valid,
  output logic [GHR_WIDTH-1:0]     ghr_out,
  output logic [GHR_WIDTH-1:0]     arch_ghr_out,
  output logic [CKPT_ID_WIDTH:0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int CNT_W = CKPT_ID_WIDTH + 1;

  logic [GHR_WIDTH-1:0]     ghr_q, ghr_d;
  logic [GHR_WIDTH-1:0]     arch_ghr_q, arch_ghr_d;
  logic [CKPT_ID_WIDTH-1:0] head_q, head_d;
  logic [CKPT_ID_WIDTH-1:0] tail_q, tail_d;
  logic [CNT_W-1:0]         count_q, count_d;

  logic                     pred_fire;
  spec_op_e                 op;
  logic [GHR_WIDTH-1:0]     ckpt_rd_data;
  logic [CKPT_ID_WIDTH-1:0] rec_off;
  logic [CNT_W-1:0]         rec_span;

  // Status flags come only from registered state, so commit never opens a
  // combinational path into pred_ready.
  always_comb begin
    full       = (count_q == CNT_W'(CKPT_DEPTH));
    empty      = (count_q == '0);
    pred_ready = !full && !recover_valid && !flush_valid;
    pred_fire  = pred_valid && pred_ready;
    pred_id    = tail_q;
    ghr_out      = ghr_q;
    arch_ghr_out = arch_ghr_q;
    count        = count_q;
  end

  // Pick the single speculative-history update for this cycle.
  always_comb begin
    op = OP_IDLE;
    if (flush_valid) begin
      op = OP_FLUSH;
    end else if (recover_valid) begin
      op = OP_RECOVER;
    end else if (pred_fire) begin
      op = OP_PRED;
    end
  end

  // Live entries from head up to and including the mispredicted branch;
  // ranges 1..CKPT_DEPTH so a ring that stays full is still counted right.
  always_comb begin
    rec_off  = recover_id - head_q;
    rec_span = {1'b0, rec_off} + CNT_W'(1);
  end

  ghr_ckpt_ram #(
    .WIDTH    (GHR_WIDTH),
    .DEPTH    (CKPT_DEPTH),
    .ID_WIDTH (CKPT_ID_WIDTH)
  ) u_ram (
    .clk     (clk),
    .wr_en   (pred_fire && rst),
    .wr_addr (tail_q),
    .wr_data (ghr_q),
    .rd_addr (recover_id),
    .rd_data (ckpt_rd_data)
  );

  // Next-state for both histories, ring pointers and occupancy; commit
  // always applies alongside whichever speculative update wins.
  always_comb begin
    arch_ghr_d = commit_valid ? {arch_ghr_q[GHR_WIDTH-2:0], commit_taken} : arch_ghr_q;
    head_d     = head_q + CKPT_ID_WIDTH'(commit_valid);
    ghr_d      = ghr_q;
    tail_d     = tail_q;
    count_d    = count_q - CNT_W'(commit_valid);
    case (op)
      OP_FLUSH: begin
        ghr_d   = arch_ghr_d;
        head_d  = '0;
        tail_d  = '0;
        count_d = '0;
      end
      OP_RECOVER: begin
        ghr_d   = (ckpt_rd_data << 1) | {{(GHR_WIDTH-1){1'b0}}, recover_taken};
        tail_d  = recover_id + CKPT_ID_WIDTH'(1);
        count_d = rec_span - CNT_W'(commit_valid);
      end
      OP_PRED: begin
        ghr_d   = {ghr_q[GHR_WIDTH-2:0], pred_taken};
        tail_d  = tail_q + CKPT_ID_WIDTH'(1);
        count_d = count_q + CNT_W'(1) - CNT_W'(commit_valid);
      end
      default: begin
      end
    endcase
  end

  // State registers; reset drops every in-flight checkpoint.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ghr_q      <= '0;
      arch_ghr_q <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
    end else begin
      ghr_q      <= ghr_d;
      arch_ghr_q <= arch_ghr_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
    end
  end

endmodule
